// File: rtl/uart_pkg.sv
// Shared UART definitions: the receive/transmit state encoding and the
// derivation of bit and half-bit periods in clock cycles from the clock
// frequency and line rate. Used by both uart_rx and uart_tx.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_state_e;

   // Clock cycles per line bit (integer division, truncating)
   function automatic int unsigned calc_bitcycle(input int unsigned clk_freq,
                                                 input int unsigned baudrate);
      return clk_freq / baudrate;
   endfunction

   // Clock cycles to the middle of a line bit
   function automatic int unsigned calc_halfcycle(input int unsigned clk_freq,
                                                  input int unsigned baudrate);
      return calc_bitcycle(clk_freq, baudrate) / 2;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous single-bit input into
// the clk domain. Both flops reset to RESET_VAL so that an idle line does
// not look like an edge when reset is released.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rstb,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   // Next-state of the two synchronizer stages
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer register chain with asynchronous reset to RESET_VAL
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversamples the synchronized serial line with a cycle
// counter, checks the start bit at its midpoint, samples each data bit at
// the middle of its bit period (LSB first) and checks the stop bit. A good
// frame updates data with a one-cycle data_valid pulse; a low stop bit
// gives a one-cycle frame_err pulse and the receiver then waits in BREAK
// until the line returns high, so a held-low line reports only once.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUDRATE = 115200,
   parameter int CLK_FREQ = 100_000_000,
   parameter int BITLEN   = 8
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              rx,
   output logic [BITLEN-1:0] data,
   output logic              data_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int unsigned BITCYCLE  = calc_bitcycle(CLK_FREQ, BAUDRATE);
   localparam int unsigned HALFCYCLE = calc_halfcycle(CLK_FREQ, BAUDRATE);
   localparam int          CNT_W     = $clog2(BITCYCLE);
   localparam int          IDX_W     = $clog2(BITLEN) + 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BITCYCLE - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALFCYCLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BITLEN - 1);

   logic rx_s;

   uart_state_e       state_q,      state_d;
   logic [CNT_W-1:0]  count_q,      count_d;
   logic [IDX_W-1:0]  index_q,      index_d;
   logic [BITLEN-1:0] shift_q,      shift_d;
   logic [BITLEN-1:0] data_q,       data_d;
   logic              data_valid_q, data_valid_d;
   logic              frame_err_q,  frame_err_d;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk  (clk),
      .rstb (rstb),
      .d    (rx),
      .q    (rx_s)
   );

   // Frame FSM: bit timing, data shifting and result/pulse generation
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      index_d      = index_q;
      shift_d      = shift_q;
      data_d       = data_q;
      data_valid_d = 1'b0;
      frame_err_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            count_d = '0;
            index_d = '0;
            if (!rx_s) begin
               state_d = ST_START;
            end
         end

         ST_START: begin
            if (count_q == HALF_LAST) begin
               count_d = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               count_d = count_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (count_q == BIT_LAST) begin
               count_d = '0;
               shift_d = {rx_s, shift_q[BITLEN-1:1]};
               if (index_q == IDX_LAST) begin
                  index_d = '0;
                  state_d = ST_STOP;
               end else begin
                  index_d = index_q + 1'b1;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end

         ST_STOP: begin
            if (count_q == BIT_LAST) begin
               count_d = '0;
               if (rx_s) begin
                  data_d       = shift_q;
                  data_valid_d = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_BREAK;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end

         ST_BREAK: begin
            count_d = '0;
            index_d = '0;
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            count_d = '0;
            index_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Receiver state registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         index_q      <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         index_q      <= index_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 100 MHz / 115200 baud / 8 data bits.
// The line is driven on falling clock edges, 868 clocks per bit; outputs
// are observed on falling edges. A monitor counts pulses and logs the
// received words and their times.
module tb_uart_rx;

   localparam int BITCYC  = 868;
   localparam int HALFCYC = 434;

   logic       clk  = 1'b0;
   logic       rstb = 1'b0;
   logic       rx   = 1'b1;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   int n_compared   = 0;
   int n_mismatched = 0;

   int         dv_count   = 0;
   int         fe_count   = 0;
   int         both_count = 0;
   logic [7:0] dv_data[$];
   longint     dv_time[$];

   uart_rx #(
      .BAUDRATE (115200),
      .CLK_FREQ (100_000_000),
      .BITLEN   (8)
   ) dut (
      .clk        (clk),
      .rstb       (rstb),
      .rx         (rx),
      .data       (data),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   // 100 MHz clock: rising edges at 5, 15, 25 ... ns
   always #5 clk = ~clk;

   // Pulse monitor sampled away from the active edge
   always @(negedge clk) begin
      if (data_valid) begin
         dv_count++;
         dv_data.push_back(data);
         dv_time.push_back($time);
      end
      if (frame_err) fe_count++;
      if (data_valid && frame_err) both_count++;
   end

   task automatic clear_monitor();
      dv_count = 0;
      fe_count = 0;
      dv_data.delete();
      dv_time.delete();
   endtask

   // Drives one frame starting at the current falling edge
   task automatic send_frame(input logic [7:0] value, input logic stop_bit);
      rx = 1'b0;
      repeat (BITCYC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = value[i];
         repeat (BITCYC) @(negedge clk);
      end
      rx = stop_bit;
      repeat (BITCYC) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      rstb = 1'b0;
      rx   = 1'b1;
      repeat (3) @(negedge clk);
      n_compared++;
      if (data !== 8'h00) begin
         n_mismatched++;
         $display("[TB] FAIL reset_data: got %h expected %h", data, 8'h00);
      end
      n_compared++;
      if (data_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_data_valid: got %b expected 0", data_valid);
      end
      n_compared++;
      if (frame_err !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err);
      end
      n_compared++;
      if (busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_busy: got %b expected 0", busy);
      end
      rstb = 1'b1;
      repeat (10) @(negedge clk);
      n_compared++;
      if (busy !== 1'b0 || dv_count != 0 || fe_count != 0) begin
         n_mismatched++;
         $display("[TB] FAIL idle_after_reset: busy %b dv %0d fe %0d expected 0 0 0",
                  busy, dv_count, fe_count);
      end
   endtask

   task automatic test_single_frame();
      longint t_start;
      longint latency;
      clear_monitor();
      t_start = $time;
      send_frame(8'hA5, 1'b1);
      n_compared++;
      if (dv_count != 1) begin
         n_mismatched++;
         $display("[TB] FAIL a5_pulse_count: got %0d expected 1", dv_count);
      end
      n_compared++;
      if (data !== 8'hA5) begin
         n_mismatched++;
         $display("[TB] FAIL a5_data: got %h expected a5", data);
      end
      n_compared++;
      if (fe_count != 0) begin
         n_mismatched++;
         $display("[TB] FAIL a5_frame_err: got %0d pulses expected 0", fe_count);
      end
      n_compared++;
      if (busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL a5_busy_after: got %b expected 0", busy);
      end
      // First rising edge with rx low is 5 ns after t_start; expected 8248 cycles
      latency = (dv_time.size() > 0) ? (dv_time[0] - t_start - 5) / 10 : -1;
      n_compared++;
      if (latency < 8246 || latency > 8250) begin
         n_mismatched++;
         $display("[TB] FAIL a5_latency: got %0d cycles expected 8248 +/-2", latency);
      end
   endtask

   task automatic test_glitch();
      logic [7:0] prev;
      int         waited;
      logic       busy_mid;
      clear_monitor();
      prev = data;
      rx   = 1'b0;
      repeat (100) @(negedge clk);
      busy_mid = busy;
      repeat (100) @(negedge clk);
      rx     = 1'b1;
      waited = 200;
      while (busy && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      n_compared++;
      if (busy_mid !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL glitch_busy_during: got %b expected 1", busy_mid);
      end
      // Start is checked at mid-bit: back to IDLE about 437 cycles after the fall
      n_compared++;
      if (waited < 400 || waited > 440) begin
         n_mismatched++;
         $display("[TB] FAIL glitch_idle_time: got %0d cycles expected 400..440", waited);
      end
      n_compared++;
      if (dv_count != 0 || fe_count != 0) begin
         n_mismatched++;
         $display("[TB] FAIL glitch_pulses: dv %0d fe %0d expected 0 0", dv_count, fe_count);
      end
      n_compared++;
      if (data !== prev) begin
         n_mismatched++;
         $display("[TB] FAIL glitch_data: got %h expected %h", data, prev);
      end
      repeat (HALFCYC) @(negedge clk);
   endtask

   task automatic test_frame_error();
      logic [7:0] prev;
      clear_monitor();
      prev = data;
      send_frame(8'h3C, 1'b0);
      repeat (BITCYC) @(negedge clk);
      n_compared++;
      if (fe_count != 1) begin
         n_mismatched++;
         $display("[TB] FAIL ferr_count: got %0d expected 1", fe_count);
      end
      n_compared++;
      if (dv_count != 0) begin
         n_mismatched++;
         $display("[TB] FAIL ferr_no_valid: got %0d pulses expected 0", dv_count);
      end
      n_compared++;
      if (data !== prev) begin
         n_mismatched++;
         $display("[TB] FAIL ferr_data_held: got %h expected %h", data, prev);
      end
      n_compared++;
      if (busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL ferr_busy_after: got %b expected 0", busy);
      end
      clear_monitor();
      send_frame(8'h55, 1'b1);
      n_compared++;
      if (dv_count != 1 || data !== 8'h55) begin
         n_mismatched++;
         $display("[TB] FAIL ferr_recover: dv %0d data %h expected 1 55", dv_count, data);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] expected[3];
      longint     gap;
      expected[0] = 8'h00;
      expected[1] = 8'hFF;
      expected[2] = 8'h81;
      clear_monitor();
      for (int i = 0; i < 3; i++) send_frame(expected[i], 1'b1);
      n_compared++;
      if (dv_count != 3) begin
         n_mismatched++;
         $display("[TB] FAIL b2b_count: got %0d expected 3", dv_count);
      end
      for (int i = 0; i < 3; i++) begin
         n_compared++;
         if (dv_data.size() <= i || dv_data[i] !== expected[i]) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_data%0d: got %h expected %h", i,
                     (dv_data.size() > i) ? dv_data[i] : 8'hxx, expected[i]);
         end
      end
      for (int i = 1; i < 3; i++) begin
         gap = (dv_time.size() > i) ? (dv_time[i] - dv_time[i-1]) / 10 : -1;
         n_compared++;
         if (gap < 8678 || gap > 8682) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_spacing%0d: got %0d cycles expected 8680", i, gap);
         end
      end
      n_compared++;
      if (fe_count != 0) begin
         n_mismatched++;
         $display("[TB] FAIL b2b_frame_err: got %0d expected 0", fe_count);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] value;
      value = 8'h7E;
      clear_monitor();
      rx = 1'b0;
      repeat (BITCYC) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = value[i];
         repeat (BITCYC) @(negedge clk);
      end
      rx = value[4];
      repeat (HALFCYC) @(negedge clk);
      rstb = 1'b0;
      @(negedge clk);
      n_compared++;
      if (data !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL midrst_outputs: data %h dv %b fe %b busy %b expected 00 0 0 0",
                  data, data_valid, frame_err, busy);
      end
      rx = 1'b1;
      @(negedge clk);
      rstb = 1'b1;
      repeat (2 * BITCYC) @(negedge clk);
      n_compared++;
      if (dv_count != 0 || fe_count != 0 || busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL midrst_no_pulse: dv %0d fe %0d busy %b expected 0 0 0",
                  dv_count, fe_count, busy);
      end
      clear_monitor();
      send_frame(8'h12, 1'b1);
      n_compared++;
      if (dv_count != 1 || data !== 8'h12) begin
         n_mismatched++;
         $display("[TB] FAIL midrst_next_frame: dv %0d data %h expected 1 12", dv_count, data);
      end
   endtask

   task automatic test_break();
      logic [7:0] prev;
      clear_monitor();
      prev = data;
      rx   = 1'b0;
      repeat (20 * BITCYC) @(negedge clk);
      n_compared++;
      if (busy !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL break_busy_held: got %b expected 1", busy);
      end
      rx = 1'b1;
      repeat (BITCYC) @(negedge clk);
      n_compared++;
      if (fe_count != 1 || dv_count != 0) begin
         n_mismatched++;
         $display("[TB] FAIL break_pulses: fe %0d dv %0d expected 1 0", fe_count, dv_count);
      end
      n_compared++;
      if (busy !== 1'b0 || data !== prev) begin
         n_mismatched++;
         $display("[TB] FAIL break_release: busy %b data %h expected 0 %h", busy, data, prev);
      end
      clear_monitor();
      send_frame(8'hC3, 1'b1);
      n_compared++;
      if (dv_count != 1 || data !== 8'hC3) begin
         n_mismatched++;
         $display("[TB] FAIL break_next_frame: dv %0d data %h expected 1 c3", dv_count, data);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_glitch();
      test_frame_error();
      test_back_to_back();
      test_reset_mid_frame();
      test_break();
      n_compared++;
      if (both_count != 0) begin
         n_mismatched++;
         $display("[TB] FAIL exclusive_pulses: got %0d overlapping cycles expected 0", both_count);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
